// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, stable-time debounce, press/release/long strobes.
// Optional auto-repeat strobes are built only when the macro KEY_REPEAT_EN is defined.
module key_debounce_multi #(
   parameter int KEY_NUM     = 4,
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200
) (
   input  logic               CLK_50M,
   input  logic               RST,
   input  logic [KEY_NUM-1:0] KEY,
   output logic [KEY_NUM-1:0] key_level,
   output logic [KEY_NUM-1:0] key_press,
   output logic [KEY_NUM-1:0] key_release,
   output logic [KEY_NUM-1:0] key_long,
   output logic [KEY_NUM-1:0] key_repeat
);

   localparam int MS_CYC = CLK_FREQ_HZ / 1000;
   localparam int DB_CYC = DEBOUNCE_MS * MS_CYC;
   localparam int MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
   localparam int DB_W   = $clog2(DB_CYC);
   localparam int HOLD_W = $clog2(LONG_MS + 1);

   localparam logic [MS_W-1:0]   MS_LAST  = MS_W'(MS_CYC - 1);
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_MS - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);

   logic [KEY_NUM-1:0] sync_1;
   logic [KEY_NUM-1:0] sync_2;
   logic [KEY_NUM-1:0] sample;
   logic [MS_W-1:0]    ms_cnt;
   logic               tick;

   // Pins idle high, so the synchroniser resets to the released level.
   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         sync_1 <= '1;
         sync_2 <= '1;
      end else begin
         sync_1 <= KEY;
         sync_2 <= sync_1;
      end
   end

   assign sample = ~sync_2;

   always_ff @(posedge CLK_50M) begin
      if (RST || tick) begin
         ms_cnt <= '0;
      end else begin
         ms_cnt <= ms_cnt + MS_W'(1);
      end
   end

   assign tick = (ms_cnt == MS_LAST);

   genvar k;
   generate
      for (k = 0; k < KEY_NUM; k++) begin : g_key
         logic [DB_W-1:0]   db_cnt;
         logic [HOLD_W-1:0] hold_cnt;
         logic              level_q;
         logic              press_q;
         logic              release_q;
         logic              long_q;
         logic              db_done;
         logic              long_evt;

         // db_done marks the edge where the new level has been stable long enough.
         assign db_done  = (sample[k] != level_q) && (db_cnt == DB_LAST);
         assign long_evt = level_q && tick && (hold_cnt == HOLD_PRE);

         always_ff @(posedge CLK_50M) begin
            if (RST) begin
               db_cnt    <= '0;
               hold_cnt  <= '0;
               level_q   <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
               long_q    <= 1'b0;
            end else begin
               press_q   <= db_done && sample[k];
               release_q <= db_done && !sample[k];
               long_q    <= long_evt;

               if (sample[k] == level_q) begin
                  db_cnt <= '0;
               end else if (db_done) begin
                  level_q <= sample[k];
                  db_cnt  <= '0;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end

               if (!level_q) begin
                  hold_cnt <= '0;
               end else if (tick && (hold_cnt != HOLD_MAX)) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
         end

         assign key_level[k]   = level_q;
         assign key_press[k]   = press_q;
         assign key_release[k] = release_q;
         assign key_long[k]    = long_q;

`ifdef KEY_REPEAT_EN
         localparam int REP_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;
         localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);

         logic [REP_W-1:0] rep_cnt;
         logic             rep_q;
         logic             rep_evt;

         // A saturated hold counter means key_long has already fired for this press.
         assign rep_evt = level_q && tick && (hold_cnt == HOLD_MAX) && (rep_cnt == REP_LAST);

         always_ff @(posedge CLK_50M) begin
            if (RST) begin
               rep_cnt <= '0;
               rep_q   <= 1'b0;
            end else begin
               rep_q <= rep_evt && !db_done;
               if (!level_q || long_evt) begin
                  rep_cnt <= '0;
               end else if (tick && (hold_cnt == HOLD_MAX)) begin
                  rep_cnt <= rep_evt ? '0 : rep_cnt + REP_W'(1);
               end
            end
         end

         assign key_repeat[k] = rep_q;
`else
         assign key_repeat[k] = 1'b0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: a stable-time reference model queues the expected outputs
// for every edge, a negedge monitor compares them against the DUT.
module tb_key_debounce_multi;

   localparam int KEY_NUM     = 4;
   localparam int CLK_FREQ_HZ = 10000;
   localparam int DEBOUNCE_MS = 2;
   localparam int LONG_MS     = 5;
   localparam int REPEAT_MS   = 3;
   localparam int MS_CYC      = CLK_FREQ_HZ / 1000;
   localparam int DB_CYC      = DEBOUNCE_MS * MS_CYC;
   localparam int MAXE        = 20000;

   typedef logic [5*KEY_NUM-1:0] out_vec_t;

   logic               CLK_50M = 1'b0;
   logic               RST = 1'b1;
   logic [KEY_NUM-1:0] KEY = '1;
   logic [KEY_NUM-1:0] key_level;
   logic [KEY_NUM-1:0] key_press;
   logic [KEY_NUM-1:0] key_release;
   logic [KEY_NUM-1:0] key_long;
   logic [KEY_NUM-1:0] key_repeat;

   int checks = 0;
   int errors = 0;
   out_vec_t exp_q[$];

   int press_cnt[KEY_NUM];
   int release_cnt[KEY_NUM];
   int long_cnt[KEY_NUM];
   int repeat_cnt[KEY_NUM];

   logic [KEY_NUM-1:0] eff_hist[MAXE];
   bit                 rst_hist[MAXE];
   int                 stable_since[KEY_NUM];
   bit                 prev_sample[KEY_NUM];
   bit                 m_level[KEY_NUM];
   int                 hold_ticks[KEY_NUM];
   bit                 long_seen[KEY_NUM];
   int                 ticks_since_long[KEY_NUM];
   int                 last_rst = 0;

   key_debounce_multi #(
      .KEY_NUM(KEY_NUM), .CLK_FREQ_HZ(CLK_FREQ_HZ), .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)
   ) dut (
      .CLK_50M(CLK_50M), .RST(RST), .KEY(KEY),
      .key_level(key_level), .key_press(key_press), .key_release(key_release),
      .key_long(key_long), .key_repeat(key_repeat)
   );

   always #5 CLK_50M = ~CLK_50M;

   // Reference model: a level flips once the synchronised sample has differed from it for DB_CYC
   // consecutive edges; long and repeat strobes are counted in ms ticks since reset.
   initial begin
      int e;
      e = 0;
      for (int k = 0; k < KEY_NUM; k++) begin
         press_cnt[k] = 0; release_cnt[k] = 0; long_cnt[k] = 0; repeat_cnt[k] = 0;
      end
      forever begin
         logic [KEY_NUM-1:0] lv, pr, rl, lg, rp;
         bit tick;
         @(posedge CLK_50M);
         if (e >= MAXE) begin
            $display("[TB] FAIL model_capacity: edge %0d exceeds history size %0d", e, MAXE);
            $fatal(1, "[TB] history overflow");
         end
         rst_hist[e] = RST;
         eff_hist[e] = RST ? '1 : KEY;
         lv = '0; pr = '0; rl = '0; lg = '0; rp = '0;
         if (RST) begin
            last_rst = e;
            for (int k = 0; k < KEY_NUM; k++) begin
               m_level[k] = 0; prev_sample[k] = 0; stable_since[k] = e;
               hold_ticks[k] = 0; long_seen[k] = 0; ticks_since_long[k] = 0;
            end
         end else begin
            tick = (e > last_rst) && (((e - last_rst) % MS_CYC) == 0);
            for (int k = 0; k < KEY_NUM; k++) begin
               bit s, lvl, flip, long_ev, rep_ev;
               s = (e < 2 || rst_hist[e-1]) ? 1'b0 : ~eff_hist[e-2][k];
               if (s != prev_sample[k]) begin
                  stable_since[k] = e;
                  prev_sample[k]  = s;
               end
               lvl     = m_level[k];
               flip    = (s != lvl) && ((e - stable_since[k]) >= DB_CYC - 1);
               long_ev = lvl && tick && (hold_ticks[k] == LONG_MS - 1);
               rep_ev  = 0;
               if (lvl && long_seen[k] && tick) begin
                  ticks_since_long[k]++;
`ifdef KEY_REPEAT_EN
                  rep_ev = ((ticks_since_long[k] % REPEAT_MS) == 0) && !flip;
`endif
               end
               if (long_ev) begin
                  long_seen[k] = 1;
                  ticks_since_long[k] = 0;
               end
               if (!lvl) begin
                  hold_ticks[k] = 0; long_seen[k] = 0; ticks_since_long[k] = 0;
               end else if (tick && hold_ticks[k] < LONG_MS) begin
                  hold_ticks[k]++;
               end
               m_level[k] = lvl ^ flip;
               lv[k] = m_level[k];
               pr[k] = flip && s;
               rl[k] = flip && !s;
               lg[k] = long_ev;
               rp[k] = rep_ev;
            end
         end
         exp_q.push_back({lv, pr, rl, lg, rp});
         e++;
      end
   end

   task automatic checkOutput(input out_vec_t expv);
      out_vec_t act;
      act = {key_level, key_press, key_release, key_long, key_repeat};
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL outputs @%0t: got lvl=%b prs=%b rel=%b lng=%b rep=%b, want lvl=%b prs=%b rel=%b lng=%b rep=%b",
                  $time, act[19:16], act[15:12], act[11:8], act[7:4], act[3:0],
                  expv[19:16], expv[15:12], expv[11:8], expv[7:4], expv[3:0]);
      end
   endtask

   // Monitor: one expected vector per edge, compared half a cycle later.
   initial begin
      forever begin
         @(negedge CLK_50M);
         if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
            for (int k = 0; k < KEY_NUM; k++) begin
               press_cnt[k]   += int'(key_press[k]);
               release_cnt[k] += int'(key_release[k]);
               long_cnt[k]    += int'(key_long[k]);
               repeat_cnt[k]  += int'(key_repeat[k]);
            end
         end
      end
   end

   task automatic applyStimulus(input logic rst, input logic [KEY_NUM-1:0] key, input int cycles);
      RST = rst;
      KEY = key;
      repeat (cycles) @(negedge CLK_50M);
   endtask

   task automatic checkCount(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: counted %0d, expected %0d", name, actual, expected);
      end
   endtask

   initial begin
      int exp_rep;
`ifdef KEY_REPEAT_EN
      exp_rep = 4;
`else
      exp_rep = 0;
`endif
      applyStimulus(1'b1, 4'hF, 5);
      applyStimulus(1'b0, 4'hF, 100);
      #1 checkCount("idle_press0", press_cnt[0], 0);

      applyStimulus(1'b0, 4'b1110, 60);
      applyStimulus(1'b0, 4'hF, 60);
      #1 checkCount("clean_press0", press_cnt[0], 1);
      checkCount("clean_release0", release_cnt[0], 1);

      applyStimulus(1'b0, 4'b1101, 15);
      applyStimulus(1'b0, 4'hF, 3);
      applyStimulus(1'b0, 4'b1101, 15);
      applyStimulus(1'b0, 4'hF, 40);
      #1 checkCount("bounce_press1", press_cnt[1], 0);
      applyStimulus(1'b0, 4'b1101, 40);
      applyStimulus(1'b0, 4'hF, 40);
      #1 checkCount("steady_press1", press_cnt[1], 1);

      applyStimulus(1'b0, 4'b1011, 80);
      applyStimulus(1'b0, 4'hF, 40);
      applyStimulus(1'b0, 4'b1011, 35);
      applyStimulus(1'b0, 4'hF, 40);
      #1 checkCount("long2", long_cnt[2], 1);

      applyStimulus(1'b0, 4'b1001, 40);
      applyStimulus(1'b1, 4'b1001, 2);
      applyStimulus(1'b0, 4'b1001, 40);
      applyStimulus(1'b0, 4'hF, 40);
      #1 checkCount("reset_repress1", press_cnt[1], 3);
      checkCount("reset_repress2", press_cnt[2], 4);

      applyStimulus(1'b0, 4'b0111, 180);
      applyStimulus(1'b0, 4'hF, 60);
      #1 checkCount("long3", long_cnt[3], 1);
      checkCount("repeat3", repeat_cnt[3], exp_rep);

      for (int i = 0; i < 60; i++) begin
         logic [KEY_NUM-1:0] nk;
         nk = KEY ^ KEY_NUM'($urandom);
         if ($urandom_range(0, 19) == 0) applyStimulus(1'b1, KEY, 2);
         applyStimulus(1'b0, nk, int'($urandom_range(1, 60)));
      end
      applyStimulus(1'b0, 4'hF, 80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
